// File: rtl/vbsme_pkg.sv
// Purpose: shared widths and FSM state encoding for the SAD search sequencer.
// Latency: n/a (type and constant definitions only).
// Backpressure: n/a.
package vbsme_pkg;

    localparam int PIX_W = 8;
    localparam int SAD_W = 32;
    localparam int IDX_W = 16;

    // Sequencer states, kept as plain constants so legacy tooling can read them.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_CMP   = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/sad_sequencer_if.sv
// Purpose: bundles the search control, pixel handshake and result signals.
// Latency: n/a (wiring only).
// Backpressure: PixReady qualifies PixValid; no other flow control.
// Ports: master drives Start/PixValid/PixA/PixB and observes results;
//        slave (the sequencer) drives PixReady, Sad/SadValid, MinSad/MinIndex, Busy, Done.
interface sad_sequencer_if;
    import vbsme_pkg::*;

    logic             Start;
    logic             PixValid;
    logic             PixReady;
    logic [PIX_W-1:0] PixA;
    logic [PIX_W-1:0] PixB;
    logic [SAD_W-1:0] Sad;
    logic             SadValid;
    logic [SAD_W-1:0] MinSad;
    logic [IDX_W-1:0] MinIndex;
    logic             Busy;
    logic             Done;

    modport master (
        output Start, PixValid, PixA, PixB,
        input  PixReady, Sad, SadValid, MinSad, MinIndex, Busy, Done
    );

    modport slave (
        input  Start, PixValid, PixA, PixB,
        output PixReady, Sad, SadValid, MinSad, MinIndex, Busy, Done
    );

endinterface

// File: rtl/sad_sequencer_adder.sv
// Purpose: 32-bit combinational adder shared by the SAD accumulator.
// Latency: combinational, zero cycles.
// Backpressure: none.
// Ports: a, b operands; sum = a + b, wrapping modulo 2^32.
module Adder
    import vbsme_pkg::*;
(
    input  logic [SAD_W-1:0] a,
    input  logic [SAD_W-1:0] b,
    output logic [SAD_W-1:0] sum
);

    assign sum = a + b;

endmodule

// File: rtl/sad_sequencer.sv
// Purpose: walks NUM_CAND candidate blocks, accumulates |A-B| per block and tracks the minimum SAD.
// Latency: Sad valid the cycle after a block's last accepted pixel; Done one cycle after the last SadValid.
// Backpressure: PixReady high only while accumulating; PixValid gaps simply stall the block.
// Ports: Clk, Rst (sync, active-high); bus (slave modport) carries Start, pixel handshake and results.
module sad_sequencer
    import vbsme_pkg::*;
#(
    parameter int BLOCK_PIXELS = 16,
    parameter int NUM_CAND     = 64
) (
    input  logic             Clk,
    input  logic             Rst,
    sad_sequencer_if.slave   bus
);

    localparam logic [IDX_W-1:0] LAST_PIX  = IDX_W'(BLOCK_PIXELS - 1);
    localparam logic [IDX_W-1:0] LAST_CAND = IDX_W'(NUM_CAND - 1);

    logic [1:0]       state;
    logic [SAD_W-1:0] acc;
    logic [SAD_W-1:0] acc_sum;
    logic [SAD_W-1:0] pix_diff;
    logic [SAD_W-1:0] sad_q;
    logic [SAD_W-1:0] min_sad_q;
    logic [IDX_W-1:0] min_idx_q;
    logic [IDX_W-1:0] pix_cnt;
    logic [IDX_W-1:0] cand_cnt;

    // Absolute difference of the presented pair, zero-extended into the adder width.
    always_comb begin
        pix_diff = '0;
        if (bus.PixA >= bus.PixB) begin
            pix_diff[PIX_W-1:0] = bus.PixA - bus.PixB;
        end else begin
            pix_diff[PIX_W-1:0] = bus.PixB - bus.PixA;
        end
    end

    Adder u_adder (
        .a   (acc),
        .b   (pix_diff),
        .sum (acc_sum)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state     <= ST_IDLE;
            acc       <= '0;
            pix_cnt   <= '0;
            cand_cnt  <= '0;
            sad_q     <= '0;
            min_sad_q <= '1;
            min_idx_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // Results of the previous search stay visible until a new one starts.
                    if (bus.Start) begin
                        acc       <= '0;
                        pix_cnt   <= '0;
                        cand_cnt  <= '0;
                        min_sad_q <= '1;
                        min_idx_q <= '0;
                        state     <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (bus.PixValid) begin
                        acc <= acc_sum;
                        if (pix_cnt == LAST_PIX) begin
                            // Final pair: publish the full sum on this same edge.
                            pix_cnt <= '0;
                            sad_q   <= acc_sum;
                            state   <= ST_CMP;
                        end else begin
                            pix_cnt <= pix_cnt + 16'd1;
                        end
                    end
                end
                ST_CMP: begin
                    // Strict compare so a tie keeps the earlier candidate.
                    if (sad_q < min_sad_q) begin
                        min_sad_q <= sad_q;
                        min_idx_q <= cand_cnt;
                    end
                    if (cand_cnt == LAST_CAND) begin
                        state <= ST_DONE;
                    end else begin
                        cand_cnt <= cand_cnt + 16'd1;
                        acc      <= '0;
                        state    <= ST_ACCUM;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.PixReady = (state == ST_ACCUM);
    assign bus.SadValid = (state == ST_CMP);
    assign bus.Busy     = (state != ST_IDLE);
    assign bus.Done     = (state == ST_DONE);
    assign bus.Sad      = sad_q;
    assign bus.MinSad   = min_sad_q;
    assign bus.MinIndex = min_idx_q;

endmodule

// File: tb/tb_sad_sequencer.sv
// Purpose: directed, scoreboard-checked bench for sad_sequencer (16 pixels x 4 candidates).
// Latency: expects Sad the cycle after each 16th transfer and Done one cycle after the last SadValid.
// Backpressure: drives PixValid with and without gaps and waits on PixReady.
module tb_sad_sequencer;

    logic Clk;
    logic Rst;

    sad_sequencer_if bus ();

    sad_sequencer #(
        .BLOCK_PIXELS (16),
        .NUM_CAND     (4)
    ) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;
    logic [31:0] exp_q[$];
    logic [7:0]  pa[16];
    logic [7:0]  pb[16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor: pops the scoreboard on SadValid and checks result timing.
    int   xcnt = 0;
    logic last_was_final = 1'b0;
    logic prev_sv = 1'b0;
    always @(negedge Clk) begin
        if (bus.SadValid === 1'b1) begin
            logic [31:0] e;
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEADBEEF;
            chk("sad", bus.Sad, e);
            chk("sad_timing", 32'(last_was_final), 32'd1);
        end
        if (bus.Done === 1'b1) begin
            done_cnt++;
            chk("done_after_sadvalid", 32'(prev_sv), 32'd1);
        end
        prev_sv        = (bus.SadValid === 1'b1);
        last_was_final = 1'b0;
        if (Rst) begin
            xcnt = 0;
        end else if (bus.PixValid && bus.PixReady === 1'b1) begin
            xcnt++;
            if (xcnt == 16) begin
                xcnt           = 0;
                last_was_final = 1'b1;
            end
        end
    end

    // Drive one pair and return #1 after the edge on which it was accepted.
    task automatic send(input logic [7:0] a, input logic [7:0] b);
        int n = 0;
        bus.PixA     = a;
        bus.PixB     = b;
        bus.PixValid = 1'b1;
        while (bus.PixReady !== 1'b1 && n < 64) begin
            @(posedge Clk); #1;
            n++;
        end
        chk("pix_ready_wait", 32'(bus.PixReady), 32'd1);
        @(posedge Clk); #1;
        bus.PixValid = 1'b0;
    endtask

    task automatic fill_fixed(input logic [7:0] a, input logic [7:0] b);
        for (int i = 0; i < 16; i++) begin
            pa[i] = a;
            pb[i] = b;
        end
    endtask

    // Spread a target SAD over 16 pairs, alternating which side is larger.
    task automatic fill_target(input int target);
        int d;
        for (int i = 0; i < 16; i++) begin
            d = target / 16 + ((i < target % 16) ? 1 : 0);
            if (i % 2 == 0) begin
                pa[i] = 8'(20 + d);
                pb[i] = 8'd20;
            end else begin
                pa[i] = 8'd20;
                pb[i] = 8'(20 + d);
            end
        end
    endtask

    task automatic run_cand(input int gap, input bit pulse_start);
        logic [31:0] e = 32'd0;
        for (int i = 0; i < 16; i++) begin
            e += (pa[i] > pb[i]) ? 32'(pa[i] - pb[i]) : 32'(pb[i] - pa[i]);
        end
        exp_q.push_back(e);
        for (int i = 0; i < 16; i++) begin
            if (pulse_start && i == 8) bus.Start = 1'b1;
            send(pa[i], pb[i]);
            bus.Start = 1'b0;
            repeat (gap) begin
                @(posedge Clk); #1;
            end
        end
    endtask

    task automatic start_search();
        bus.Start = 1'b1;
        @(posedge Clk); #1;
        bus.Start = 1'b0;
        chk("busy_after_start", 32'(bus.Busy), 32'd1);
        chk("ready_after_start", 32'(bus.PixReady), 32'd1);
    endtask

    task automatic wait_done(input logic [31:0] exp_min, input logic [31:0] exp_idx,
                             input logic [31:0] exp_last_sad, input int exp_dones);
        int n = 0;
        while (bus.Done !== 1'b1 && n < 100) begin
            @(posedge Clk); #1;
            n++;
        end
        chk("done_seen", 32'(bus.Done), 32'd1);
        chk("min_sad", bus.MinSad, exp_min);
        chk("min_index", 32'(bus.MinIndex), exp_idx);
        @(posedge Clk); #1;
        chk("done_one_cycle", 32'(bus.Done), 32'd0);
        chk("idle_busy", 32'(bus.Busy), 32'd0);
        chk("idle_sad_hold", bus.Sad, exp_last_sad);
        chk("idle_min_hold", bus.MinSad, exp_min);
        @(posedge Clk); #1;
        chk("done_count", 32'(done_cnt), 32'(exp_dones));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_sad"},      bus.Sad, 32'd0);
        chk({tag, "_sadvalid"}, 32'(bus.SadValid), 32'd0);
        chk({tag, "_minsad"},   bus.MinSad, 32'hFFFF_FFFF);
        chk({tag, "_minindex"}, 32'(bus.MinIndex), 32'd0);
        chk({tag, "_busy"},     32'(bus.Busy), 32'd0);
        chk({tag, "_done"},     32'(bus.Done), 32'd0);
        chk({tag, "_pixready"}, 32'(bus.PixReady), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        Rst          = 1'b1;
        bus.Start    = 1'b0;
        bus.PixValid = 1'b0;
        bus.PixA     = 8'd0;
        bus.PixB     = 8'd0;

        // Reset held for two cycles.
        repeat (2) @(posedge Clk);
        #1;
        chk_reset_vals("reset");
        Rst = 1'b0;
        @(posedge Clk); #1;

        // Symmetric pairs give equal SADs; the tie keeps candidate 0.
        start_search();
        fill_fixed(8'd10, 8'd3);  run_cand(0, 1'b0);
        fill_fixed(8'd3, 8'd10);  run_cand(0, 1'b0);
        fill_fixed(8'd200, 8'd0); run_cand(0, 1'b0);
        fill_fixed(8'd0, 8'd50);  run_cand(0, 1'b0);
        wait_done(32'd112, 32'd0, 32'd800, 1);

        // Minimum tracking with a later tie that must not win.
        start_search();
        fill_target(500); run_cand(0, 1'b0);
        fill_target(200); run_cand(0, 1'b0);
        fill_target(300); run_cand(0, 1'b0);
        fill_target(200); run_cand(0, 1'b0);
        wait_done(32'd200, 32'd1, 32'd200, 2);

        // Gapped PixValid at full scale, with a Start pulse mid-block that must be ignored.
        start_search();
        fill_fixed(8'd255, 8'd0);
        run_cand(1, 1'b0);
        run_cand(1, 1'b1);
        run_cand(1, 1'b0);
        run_cand(1, 1'b0);
        wait_done(32'd4080, 32'd0, 32'd4080, 3);

        // Reset after five transfers discards the partial block.
        start_search();
        fill_fixed(8'd90, 8'd10);
        for (int i = 0; i < 5; i++) send(pa[i], pb[i]);
        Rst = 1'b1;
        @(posedge Clk); #1;
        Rst = 1'b0;
        chk_reset_vals("midop_reset");

        // Reset wins over a simultaneous Start.
        Rst       = 1'b1;
        bus.Start = 1'b1;
        @(posedge Clk); #1;
        Rst       = 1'b0;
        bus.Start = 1'b0;
        chk("rst_over_start_busy", 32'(bus.Busy), 32'd0);
        @(posedge Clk); #1;

        // A full search after the abort still produces correct results.
        start_search();
        fill_target(300); run_cand(0, 1'b0);
        fill_target(100); run_cand(0, 1'b0);
        fill_target(400); run_cand(0, 1'b0);
        fill_target(100); run_cand(0, 1'b0);
        wait_done(32'd100, 32'd1, 32'd100, 4);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sad_sequencer.md
SAD_SEQUENCER -- requirements
Module: sad_sequencer

Interface
REQ-001 SHALL have parameter BLOCK_PIXELS, default 16, pixel pairs per candidate block (1..65535).
REQ-002 SHALL have parameter NUM_CAND, default 64, candidate positions per search (1..65536).
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 Port: Clk  input  1  rising-edge clock.
REQ-005 Port: Rst  input  1  synchronous active-high reset.
REQ-006 Port: Start  input  1  begin search; sampled only in IDLE.
REQ-007 Port: PixValid  input  1  pixel pair present.
REQ-008 Port: PixReady  output  1  pixel pair accepted this cycle when PixValid also high.
REQ-009 Port: PixA, PixB  input  8 each  current-block and reference-block pixels.
REQ-010 Port: Sad  output  32  SAD of the most recently completed candidate.
REQ-011 Port: SadValid  output  1  one-cycle pulse; Sad is valid.
REQ-012 Port: MinSad  output  32  smallest SAD so far in the current search.
REQ-013 Port: MinIndex  output  16  candidate number holding MinSad.
REQ-014 Port: Busy  output  1  high in every state except IDLE.
REQ-015 Port: Done  output  1  one-cycle pulse; search complete.

Function
REQ-016 FSM states SHALL be IDLE, ACCUM, CMP and DONE.
REQ-017 IDLE with Start=1 SHALL clear the accumulator and candidate counter, set MinSad=32'hFFFFFFFF and MinIndex=0, and enter ACCUM.
REQ-018 Start outside IDLE SHALL be ignored.
REQ-019 PixReady SHALL be 1 exactly when the state is ACCUM; a transfer occurs on PixValid && PixReady.
REQ-020 Each transfer SHALL add |PixA-PixB|, zero-extended to 32 bits, to the accumulator through the shared 32-bit adder; no saturation is needed.
REQ-021 The BLOCK_PIXELS-th transfer SHALL load Sad with the final sum on the same edge and enter CMP; SadValid=1 for the whole single CMP cycle.
REQ-022 PixValid gaps SHALL stall accumulation with no other effect.
REQ-023 Leaving CMP, MinSad/MinIndex SHALL update only if Sad < MinSad (strict); ties keep the earlier index.
REQ-024 Leaving CMP, if the candidate counter equals NUM_CAND-1 the FSM SHALL enter DONE; otherwise it SHALL increment the counter, clear the accumulator and return to ACCUM.
REQ-025 DONE SHALL last one cycle with Done=1, then enter IDLE.
REQ-026 MinSad, MinIndex and Sad SHALL hold their values in IDLE until the next accepted Start.

Reset
REQ-027 Rst=1 SHALL force IDLE on the next edge, from any state including mid-ACCUM, and discard partial sums.
REQ-028 Reset values SHALL be: Sad=0, SadValid=0, MinSad=32'hFFFFFFFF, MinIndex=0, Busy=0, Done=0, PixReady=0.
REQ-029 Rst SHALL take priority over Start in the same cycle.

Structure
REQ-030 Shared package vbsme_pkg SHALL hold the FSM state encoding, PIX_W=8 and SAD_W=32.
REQ-031 The accumulator add SHALL be a single instance of the existing 32-bit Adder sub-module; the absolute difference and the compare SHALL stay local.

Verification (bench: BLOCK_PIXELS=16, NUM_CAND=4)
REQ-032 Reset: assert Rst for 2 cycles -> all outputs equal the REQ-028 values; PixReady=0.
REQ-033 Symmetry/tie: candidate 0 with A=10, B=3 and candidate 1 with A=3, B=10 -> both Sad=112; MinIndex=0.
REQ-034 Min tracking: candidate SADs 500, 200, 300, 200 -> MinSad=200, MinIndex=1, one Done pulse one cycle after the 4th SadValid.
REQ-035 Stalls: PixValid toggled every other cycle with A=255, B=0 -> Sad=4080 per candidate; SadValid the cycle after the 16th transfer; Start pulsed in ACCUM is ignored.
REQ-036 Mid-op reset: Rst after 5 transfers -> IDLE next cycle with reset values; a following Start and full search gives correct results.
